init_sequencer: RTL and testbench

Scheduler that runs a chain of generated start/done function units in a fixed order, for example `init_mavlink` followed by other init steps, after a single `go` request. It issues one start pulse per step, waits for that step's completion edge, captures its result, and supervises each step with a timeout and an abort path. It sits between the top-level boot control and the generated FPGA function modules, and reports a single pass/fail status upward.

---
 rtl/init_sequencer_if.sv | 30 +++
 rtl/init_sequencer.sv | 155 +++++++++++++++
 tb/tb_init_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/init_sequencer_if.sv
// Boot-control and function-unit side signals of init_sequencer.
// The sequencer takes the slave view; whoever drives go and the units takes the master view.
interface init_sequencer_if #(
  parameter int N_STEPS = 4,
  parameter int IDX_W   = 4
) ();

  logic                  go;
  logic                  abort;
  logic [N_STEPS-1:0]    step_start;
  logic [N_STEPS-1:0]    step_done;
  logic [32*N_STEPS-1:0] step_result;
  logic                  busy;
  logic                  seq_done;
  logic                  seq_err;
  logic [1:0]            err_code;
  logic [IDX_W-1:0]      err_step;
  logic [31:0]           last_result;

  modport master (
    output go, abort, step_done, step_result,
    input  step_start, busy, seq_done, seq_err, err_code, err_step, last_result
  );

  modport slave (
    input  go, abort, step_done, step_result,
    output step_start, busy, seq_done, seq_err, err_code, err_step, last_result
  );

endinterface

// File: rtl/init_sequencer.sv
// Boot-time scheduler: after one go it starts N_STEPS function units in order,
// waits for each completion edge, and supervises every step with a timeout and abort.
module init_sequencer #(
  parameter int N_STEPS = 4,
  parameter int TIMEOUT = 255,
  parameter int IDX_W   = 4
) (
  input logic             clk,
  input logic             rst_n,
  init_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_FINISH,
    S_FAIL
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_STEPS - 1);
  localparam logic [15:0]      TIMEOUT_CNT = 16'(TIMEOUT);
  localparam logic [1:0]       ERR_NONE    = 2'b00;
  localparam logic [1:0]       ERR_TIMEOUT = 2'b01;
  localparam logic [1:0]       ERR_ABORT   = 2'b10;
  localparam logic [1:0]       ERR_UNEXP   = 2'b11;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [15:0]        timer, timer_nxt;
  logic [N_STEPS-1:0] done_q;
  logic [N_STEPS-1:0] done_edge;
  logic [N_STEPS-1:0] idx_oh;
  logic [31:0]        cur_result;
  logic               own_edge;
  logic               other_edge;
  logic [31:0]        last_result_q, last_result_nxt;
  logic               seq_err_q, seq_err_nxt;
  logic [1:0]         err_code_q, err_code_nxt;
  logic [IDX_W-1:0]   err_step_q, err_step_nxt;

  // Units hold done high after finishing, so only rising edges mean completion.
  assign done_edge  = bus.step_done & ~done_q;
  assign own_edge   = |(done_edge & idx_oh);
  assign other_edge = |(done_edge & ~idx_oh);

  always_comb begin
    idx_oh     = '0;
    cur_result = '0;
    for (int i = 0; i < N_STEPS; i++) begin
      if (idx == IDX_W'(i)) begin
        idx_oh[i]  = 1'b1;
        cur_result = bus.step_result[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      timer         <= '0;
      done_q        <= '0;
      last_result_q <= '0;
      seq_err_q     <= 1'b0;
      err_code_q    <= ERR_NONE;
      err_step_q    <= '0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      timer         <= timer_nxt;
      done_q        <= bus.step_done;
      last_result_q <= last_result_nxt;
      seq_err_q     <= seq_err_nxt;
      err_code_q    <= err_code_nxt;
      err_step_q    <= err_step_nxt;
    end
  end

  // The timer holds the number of cycles elapsed since the start pulse.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    timer_nxt       = timer;
    last_result_nxt = last_result_q;
    seq_err_nxt     = seq_err_q;
    err_code_nxt    = err_code_q;
    err_step_nxt    = err_step_q;

    case (state)
      S_IDLE: begin
        if (bus.go) begin
          idx_nxt      = '0;
          seq_err_nxt  = 1'b0;
          err_code_nxt = ERR_NONE;
          state_nxt    = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        timer_nxt = 16'd1;
        if (bus.abort) begin
          state_nxt    = S_FAIL;
          seq_err_nxt  = 1'b1;
          err_code_nxt = ERR_ABORT;
          err_step_nxt = idx;
        end else begin
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        timer_nxt = timer + 16'd1;
        if (bus.abort) begin
          state_nxt    = S_FAIL;
          seq_err_nxt  = 1'b1;
          err_code_nxt = ERR_ABORT;
          err_step_nxt = idx;
        end else if (other_edge) begin
          state_nxt    = S_FAIL;
          seq_err_nxt  = 1'b1;
          err_code_nxt = ERR_UNEXP;
          err_step_nxt = idx;
        end else if (own_edge) begin
          // Completion wins over a timeout landing in the same cycle.
          last_result_nxt = cur_result;
          if (idx == LAST_IDX) begin
            state_nxt = S_FINISH;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_LAUNCH;
          end
        end else if (timer == TIMEOUT_CNT) begin
          state_nxt    = S_FAIL;
          seq_err_nxt  = 1'b1;
          err_code_nxt = ERR_TIMEOUT;
          err_step_nxt = idx;
        end
      end

      S_FINISH: state_nxt = S_IDLE;
      S_FAIL:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign bus.step_start  = (state == S_LAUNCH) ? idx_oh : '0;
  assign bus.busy        = (state != S_IDLE);
  assign bus.seq_done    = (state == S_FINISH);
  assign bus.seq_err     = seq_err_q;
  assign bus.err_code    = err_code_q;
  assign bus.err_step    = err_step_q;
  assign bus.last_result = last_result_q;

endmodule

// File: tb/tb_init_sequencer.sv
// Randomized scoreboard bench for init_sequencer: a cycle-level plan drives the units,
// a rule-based model predicts start pulses and sequence outcomes, a monitor checks them.
module tb_init_sequencer;

  localparam int N     = 4;
  localparam int TMO   = 8;
  localparam int IW    = 4;
  localparam int NEVER = -10;

  typedef struct {
    int idx;
    int cyc;
  } start_t;

  typedef struct {
    bit          ok;
    int          code;
    int          step;
    logic [31:0] result;
    int          end_cyc;
  } end_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  start_t start_q[$];
  end_t   end_q[$];

  int          plan_rise[N];
  int          plan_s[N];
  logic [31:0] plan_res[N];
  int          plan_abort;
  logic [31:0] model_last = '0;

  init_sequencer_if #(.N_STEPS(N), .IDX_W(IW)) bus ();

  init_sequencer #(.N_STEPS(N), .TIMEOUT(TMO), .IDX_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Unit i rises at plan_rise[i] (cycles relative to go); mode 1 = step k never
  // finishes, 2 = abort during step k, 3 = unit u completes while step k is active.
  task automatic buildPlan(input int mode, input int dfix, input int k, input int at, input int u);
    int s, d;
    s          = 1;
    plan_abort = NEVER;
    for (int i = 0; i < N; i++) begin
      d            = (dfix > 0) ? dfix : int'($urandom_range(1, TMO));
      plan_s[i]    = s;
      plan_rise[i] = s + d;
      s            = s + d + 1;
      plan_res[i]  = (dfix > 0) ? 32'h11 * (i + 1) : $urandom;
    end
    case (mode)
      1: for (int i = k; i < N; i++) plan_rise[i] = NEVER;
      2: plan_abort = (at >= 0) ? at : int'($urandom_range(plan_s[k], plan_rise[k]));
      3: plan_rise[u] = (at >= 0) ? at : int'($urandom_range(plan_s[k], plan_rise[k]));
      default: ;
    endcase
  endtask

  task automatic predict(input int g, output int end_rel);
    int     s, x;
    bit     finished, stepped, other;
    end_t   e;
    start_t st;
    e.ok     = 1'b1;
    e.code   = 0;
    e.step   = 0;
    finished = 1'b0;
    end_rel  = 0;
    s        = 1;
    for (int i = 0; i < N; i++) begin
      if (!finished) begin
        st.idx = i;
        st.cyc = g + s;
        start_q.push_back(st);
        if (plan_abort == s) begin
          e.ok = 1'b0; e.code = 2; e.step = i; end_rel = s + 1; finished = 1'b1;
        end else begin
          stepped = 1'b0;
          x       = s + 1;
          while (!finished && !stepped) begin
            other = 1'b0;
            for (int j = 0; j < N; j++) if (j != i && plan_rise[j] == x) other = 1'b1;
            if (plan_abort == x) begin
              e.ok = 1'b0; e.code = 2; e.step = i; end_rel = x + 1; finished = 1'b1;
            end else if (other) begin
              e.ok = 1'b0; e.code = 3; e.step = i; end_rel = x + 1; finished = 1'b1;
            end else if (plan_rise[i] == x) begin
              model_last = plan_res[i];
              stepped    = 1'b1;
              s          = x + 1;
            end else if (x == s + TMO) begin
              e.ok = 1'b0; e.code = 1; e.step = i; end_rel = x + 1; finished = 1'b1;
            end else begin
              x++;
            end
          end
        end
      end
    end
    if (!finished) end_rel = s;
    e.result  = model_last;
    e.end_cyc = g + end_rel;
    end_q.push_back(e);
  endtask

  task automatic applyStimulus(input bit noisy, input int gap, input int rst_rel);
    int g, end_rel;
    repeat (gap) begin
      @(posedge clk); #1;
      bus.go    = 1'b0;
      bus.abort = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(posedge clk); #1;
    g = cyc;
    for (int i = 0; i < N; i++) bus.step_result[32*i +: 32] = plan_res[i];
    predict(g, end_rel);
    if (rst_rel > 0) begin
      while (start_q.size() > 0 && start_q[$].cyc > g + rst_rel) void'(start_q.pop_back());
      void'(end_q.pop_back());
      model_last = '0;
    end
    for (int rel = 0; rel <= end_rel; rel++) begin
      if (rel > 0) begin
        @(posedge clk); #1;
      end
      if (rel == 0) begin
        bus.go    = 1'b1;
        bus.abort = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        bus.go    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.abort = (rel == plan_abort);
      end
      for (int u = 0; u < N; u++) begin
        if (plan_rise[u] - 1 == rel) bus.step_done[u] = 1'b0;
        if (plan_rise[u] == rel)     bus.step_done[u] = 1'b1;
      end
      if (rel == rst_rel) begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_step_start", 64'(bus.step_start), 0);
        checkOutput("rst_busy", 64'(bus.busy), 0);
        checkOutput("rst_seq_done", 64'(bus.seq_done), 0);
        checkOutput("rst_seq_err", 64'(bus.seq_err), 0);
        checkOutput("rst_err_code", 64'(bus.err_code), 0);
        checkOutput("rst_err_step", 64'(bus.err_step), 0);
        checkOutput("rst_last_result", 64'(bus.last_result), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.go    = 1'b0;
        bus.abort = 1'b0;
        break;
      end
    end
  endtask

  // Monitor: pops expectations whenever a start pulse appears or busy falls.
  logic   prev_busy = 1'b0;
  int     done_seen = -1;
  start_t mon_st;
  end_t   mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (bus.step_start != '0) begin
        if (start_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_start: got step_start 0x%0h, expected none (cycle %0d)", bus.step_start, cyc);
        end else begin
          mon_st = start_q.pop_front();
          checkOutput("start_onehot", 64'(bus.step_start), 64'(1) << mon_st.idx);
          checkOutput("start_cycle", 64'(cyc), 64'(mon_st.cyc));
          checkOutput("busy_at_start", 64'(bus.busy), 1);
          checkOutput("seq_err_cleared", 64'(bus.seq_err), 0);
        end
      end
      if (bus.seq_done) done_seen = cyc;
      if (prev_busy && !bus.busy) begin
        if (end_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_end: busy fell, expected no sequence end (cycle %0d)", cyc);
        end else begin
          mon_e = end_q.pop_front();
          checkOutput("end_cycle", 64'(cyc - 1), 64'(mon_e.end_cyc));
          checkOutput("seq_done_pulse", 64'(done_seen == cyc - 1), 64'(mon_e.ok));
          checkOutput("seq_err", 64'(bus.seq_err), 64'(!mon_e.ok));
          checkOutput("err_code", 64'(bus.err_code), 64'(mon_e.code));
          if (!mon_e.ok) checkOutput("err_step", 64'(bus.err_step), 64'(mon_e.step));
          checkOutput("last_result", 64'(bus.last_result), 64'(mon_e.result));
        end
      end
      prev_busy = bus.busy;
    end
  end

  initial begin
    int m, k, u;
    bus.go          = 1'b0;
    bus.abort       = 1'b0;
    bus.step_done   = '0;
    bus.step_result = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("reset_busy", 64'(bus.busy), 0);
    checkOutput("reset_step_start", 64'(bus.step_start), 0);
    checkOutput("reset_seq_err", 64'(bus.seq_err), 0);
    checkOutput("reset_last_result", 64'(bus.last_result), 0);

    buildPlan(0, 3, 0, -1, 0); applyStimulus(1'b0, 1, -1);
    buildPlan(1, 3, 2, -1, 0); applyStimulus(1'b0, 1, -1);
    buildPlan(2, 3, 1, 6, 0);  applyStimulus(1'b0, 1, -1);
    buildPlan(3, 3, 0, 2, 3);  applyStimulus(1'b0, 0, -1);

    for (int r = 0; r < 40; r++) begin
      m = $urandom_range(0, 5);
      k = $urandom_range(0, N - 2);
      u = $urandom_range(k + 1, N - 1);
      case (m)
        2:       buildPlan(1, 0, int'($urandom_range(0, N - 1)), -1, 0);
        3:       buildPlan(2, 0, int'($urandom_range(0, N - 1)), -1, 0);
        4:       buildPlan(3, 0, k, -1, u);
        default: buildPlan(0, 0, 0, -1, 0);
      endcase
      applyStimulus(1'b1, int'($urandom_range(0, 2)), -1);
    end

    buildPlan(0, 3, 0, -1, 0); applyStimulus(1'b0, 1, 11);
    buildPlan(0, 3, 0, -1, 0); applyStimulus(1'b0, 1, -1);

    @(posedge clk); #1;
    bus.go    = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("pending_expectations", 64'(start_q.size() + end_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
